// File: rtl/zx_cmd_port.sv
// zx_cmd_port
// Z80-side command initiator for the SD loader's CPU command handshake.
// The Spectrum writes a command byte to CMD_PORT. The byte is latched onto
// cpu_cmd and announced with cpu_cmd_en. A four-phase handshake against
// cpu_cmd_ack then runs to completion. Z80 software polls STATUS_PORT to
// read busy, overrun and timeout.
//
// Ports:
//   clk_clk        system clock (50 MHz)
//   reset_reset_n  asynchronous active-low reset
//   z80_addr       Z80 address bus, only [7:0] decoded
//   z80_data_in    Z80 data bus as seen by the FPGA
//   z80_data_out   status byte {busy, overrun, timeout, 5'b0}
//   z80_data_oe    data bus output enable (active high)
//   z80_iorq_n     Z80 IORQ, asynchronous
//   z80_rd_n       Z80 RD, asynchronous
//   z80_wr_n       Z80 WR, asynchronous
//   z80_m1_n       Z80 M1, asynchronous (low = interrupt acknowledge)
//   cpu_cmd        latched command byte to the loader
//   cpu_cmd_en     command valid level
//   cpu_cmd_ack    loader acknowledge (same clock domain)

module zx_cmd_port #(
  parameter logic [7:0]  CMD_PORT    = 8'hE7,
  parameter logic [7:0]  STATUS_PORT = 8'hE5,
  parameter logic [23:0] TIMEOUT     = 24'd5000000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [15:0] z80_addr,
  input  logic [7:0]  z80_data_in,
  output logic [7:0]  z80_data_out,
  output logic        z80_data_oe,
  input  logic        z80_iorq_n,
  input  logic        z80_rd_n,
  input  logic        z80_wr_n,
  input  logic        z80_m1_n,
  output logic [7:0]  cpu_cmd,
  output logic        cpu_cmd_en,
  input  logic        cpu_cmd_ack
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0]  iorq_sync, rd_sync, wr_sync, m1_sync;
  logic        wr_strobe, rd_strobe;
  logic        wr_strobe_q, rd_strobe_q;
  logic        wr_rise, rd_rise, rd_fall;
  logic [7:0]  addr_q, data_q;
  logic        status_rd_active;
  logic        cmd_write, status_read_end;

  logic [7:0]  cmd_nxt;
  logic        en_nxt;
  logic [23:0] timer, timer_nxt;
  logic        overrun, overrun_nxt;
  logic        timeout, timeout_nxt;

  // The upper address byte is part of the bus but never decoded.
  logic addr_hi_unused;
  assign addr_hi_unused = ^z80_addr[15:8];

  // Two-flop synchronisers for the asynchronous Z80 control pins. They reset
  // to the inactive (high) level so that leaving reset never fakes a strobe.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      iorq_sync <= 2'b11;
      rd_sync   <= 2'b11;
      wr_sync   <= 2'b11;
      m1_sync   <= 2'b11;
    end else begin
      iorq_sync <= {iorq_sync[0], z80_iorq_n};
      rd_sync   <= {rd_sync[0], z80_rd_n};
      wr_sync   <= {wr_sync[0], z80_wr_n};
      m1_sync   <= {m1_sync[0], z80_m1_n};
    end
  end

  // Bus strobes built from the synchronised pins. M1 low marks an interrupt
  // acknowledge cycle, which must never look like an I/O access.
  assign wr_strobe = ~iorq_sync[1] & ~wr_sync[1] & m1_sync[1];
  assign rd_strobe = ~iorq_sync[1] & ~rd_sync[1] & m1_sync[1];

  // Third register stage for edge detection, plus a one-clock copy of the
  // address and data bus. By the time a synchronised strobe edge appears the
  // bus has been stable for several clocks, so the previous-clock copy is
  // safe to use.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      wr_strobe_q <= 1'b0;
      rd_strobe_q <= 1'b0;
      addr_q      <= 8'h00;
      data_q      <= 8'h00;
    end else begin
      wr_strobe_q <= wr_strobe;
      rd_strobe_q <= rd_strobe;
      addr_q      <= z80_addr[7:0];
      data_q      <= z80_data_in;
    end
  end

  assign wr_rise = wr_strobe & ~wr_strobe_q;
  assign rd_rise = rd_strobe & ~rd_strobe_q;
  assign rd_fall = ~rd_strobe & rd_strobe_q;

  assign cmd_write = wr_rise & (addr_q == CMD_PORT);

  // Remember that the read in progress targets the status port. The sticky
  // flags are cleared at the end of that read, when the address may already
  // have moved on, so the decode is taken at the start of the cycle.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      status_rd_active <= 1'b0;
    end else if (rd_rise) begin
      status_rd_active <= (addr_q == STATUS_PORT);
    end else if (rd_fall) begin
      status_rd_active <= 1'b0;
    end
  end

  assign status_read_end = rd_fall & status_rd_active;

  // Handshake state register together with the command, timer and the
  // sticky status flags. Reset drops cpu_cmd_en immediately.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= IDLE;
      cpu_cmd    <= 8'h00;
      cpu_cmd_en <= 1'b0;
      timer      <= 24'd0;
      overrun    <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cpu_cmd    <= cmd_nxt;
      cpu_cmd_en <= en_nxt;
      timer      <= timer_nxt;
      overrun    <= overrun_nxt;
      timeout    <= timeout_nxt;
    end
  end

  // Next-state logic. The status clear is applied first so that a flag being
  // set in the same clock overrides it. A command write is judged against the
  // registered state, so a write landing on the clock the FSM returns to IDLE
  // still counts as an overrun. The timer stops at TIMEOUT-1 and never wraps.
  always_comb begin
    state_nxt   = state;
    cmd_nxt     = cpu_cmd;
    en_nxt      = cpu_cmd_en;
    timer_nxt   = timer;
    overrun_nxt = overrun;
    timeout_nxt = timeout;

    if (status_read_end) begin
      overrun_nxt = 1'b0;
      timeout_nxt = 1'b0;
    end

    if (cmd_write && (state != IDLE)) begin
      overrun_nxt = 1'b1;
    end

    case (state)
      IDLE: begin
        if (cmd_write) begin
          cmd_nxt   = data_q;
          en_nxt    = 1'b1;
          timer_nxt = 24'd0;
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (cpu_cmd_ack) begin
          en_nxt    = 1'b0;
          timer_nxt = 24'd0;
          state_nxt = WAIT_REL;
        end else if (timer == (TIMEOUT - 24'd1)) begin
          en_nxt      = 1'b0;
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          timer_nxt = timer + 24'd1;
        end
      end
      WAIT_REL: begin
        if (!cpu_cmd_ack) begin
          state_nxt = IDLE;
        end else if (timer == (TIMEOUT - 24'd1)) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end else begin
          timer_nxt = timer + 24'd1;
        end
      end
      default: begin
        en_nxt    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Status read path comes straight from the raw pins so the byte is on the
  // bus within the Z80 read cycle, long before the synchronisers catch up.
  assign z80_data_oe  = ~z80_iorq_n & ~z80_rd_n & z80_m1_n &
                        (z80_addr[7:0] == STATUS_PORT);
  assign z80_data_out = {(state != IDLE), overrun, timeout, 5'b00000};

endmodule

// File: tb/tb_zx_cmd_port.sv
// tb_zx_cmd_port
// Self-checking bench for zx_cmd_port built with a short TIMEOUT of 16
// clocks. Bus-cycle tasks drive the Z80 pins, and a loader model answers
// cpu_cmd_en. Expected commands and status bytes are queued when stimulus is
// issued. A monitor pops and compares them when cpu_cmd_en rises or falls,
// or when z80_data_oe rises.

module tb_zx_cmd_port;

  logic        clk;
  logic        reset_reset_n;
  logic [15:0] z80_addr;
  logic [7:0]  z80_data_in;
  logic [7:0]  z80_data_out;
  logic        z80_data_oe;
  logic        z80_iorq_n, z80_rd_n, z80_wr_n, z80_m1_n;
  logic [7:0]  cpu_cmd;
  logic        cpu_cmd_en;
  logic        cpu_cmd_ack;

  int test_count = 0;
  int fail_count = 0;

  typedef struct {
    logic [7:0] cmd;
    int         len;
    bit         by_ack;
  } cmd_exp_t;

  cmd_exp_t   cmd_q[$];
  logic [7:0] status_q[$];

  typedef enum int {L_AUTO, L_LOW, L_HIGH} loader_mode_t;
  loader_mode_t loader_mode = L_LOW;
  int ack_delay = 5;
  int rel_delay = 3;

  zx_cmd_port #(
    .CMD_PORT    (8'hE7),
    .STATUS_PORT (8'hE5),
    .TIMEOUT     (24'd16)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (reset_reset_n),
    .z80_addr      (z80_addr),
    .z80_data_in   (z80_data_in),
    .z80_data_out  (z80_data_out),
    .z80_data_oe   (z80_data_oe),
    .z80_iorq_n    (z80_iorq_n),
    .z80_rd_n      (z80_rd_n),
    .z80_wr_n      (z80_wr_n),
    .z80_m1_n      (z80_m1_n),
    .cpu_cmd       (cpu_cmd),
    .cpu_cmd_en    (cpu_cmd_en),
    .cpu_cmd_ack   (cpu_cmd_ack)
  );

  // 100 MHz bench clock; only relative cycle counts matter.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point shared by every process.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One Z80 I/O cycle: strobes are held for three clocks and followed by a
  // three-clock gap. The output enable is checked on the first clock.
  task automatic applyStimulus(input bit is_write, input logic [15:0] addr,
                               input logic [7:0] data, input logic m1_n);
    logic exp_oe;
    @(negedge clk);
    #1;
    z80_addr    = addr;
    z80_data_in = data;
    z80_m1_n    = m1_n;
    z80_iorq_n  = 1'b0;
    if (is_write) z80_wr_n = 1'b0;
    else          z80_rd_n = 1'b0;
    @(negedge clk);
    exp_oe = !is_write && m1_n && (addr[7:0] == 8'hE5);
    checkOutput(is_write ? "oe_during_write" : "oe_during_read",
                32'(z80_data_oe), 32'(exp_oe));
    repeat (2) @(negedge clk);
    #1;
    z80_iorq_n = 1'b1;
    z80_rd_n   = 1'b1;
    z80_wr_n   = 1'b1;
    z80_m1_n   = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic z80_out(input logic [15:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, addr, data, 1'b1);
  endtask

  task automatic status_read(input logic [15:0] addr, input logic [7:0] expected);
    status_q.push_back(expected);
    applyStimulus(1'b0, addr, 8'h00, 1'b1);
  endtask

  task automatic expect_cmd(input logic [7:0] cmd, input int len, input bit by_ack);
    cmd_exp_t e;
    e.cmd    = cmd;
    e.len    = len;
    e.by_ack = by_ack;
    cmd_q.push_back(e);
  endtask

  // Loader model. In auto mode, ack rises ack_delay clocks after cpu_cmd_en
  // is first seen. It falls rel_delay clocks after cpu_cmd_en is seen low.
  initial begin : loader_model
    int phase;
    int cnt;
    phase = 0;
    cnt = 0;
    cpu_cmd_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (loader_mode == L_AUTO) begin
        case (phase)
          0: if (cpu_cmd_en) begin cnt = 0; phase = 1; end
          1: begin
            cnt++;
            if (cnt >= ack_delay) begin #1 cpu_cmd_ack = 1'b1; phase = 2; end
          end
          2: if (!cpu_cmd_en) begin cnt = 0; phase = 3; end
          default: begin
            cnt++;
            if (cnt >= rel_delay) begin #1 cpu_cmd_ack = 1'b0; phase = 0; end
          end
        endcase
      end else begin
        phase = 0;
        #1 cpu_cmd_ack = (loader_mode == L_HIGH);
      end
    end
  end

  // Monitor: compares queued expectations against what the DUT presents.
  initial begin : monitor
    logic     en_prev, oe_prev;
    int       en_len;
    bit       cur_valid;
    cmd_exp_t cur;
    logic [7:0] st;
    en_prev = 1'b0;
    oe_prev = 1'b0;
    en_len = 0;
    cur_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (cpu_cmd_en && !en_prev) begin
        en_len = 1;
        checkOutput("cmd_expected", 32'(cmd_q.size() != 0), 32'd1);
        if (cmd_q.size() != 0) begin
          cur = cmd_q.pop_front();
          cur_valid = 1'b1;
          checkOutput("cmd_value", 32'(cpu_cmd), 32'(cur.cmd));
        end
      end else if (cpu_cmd_en) begin
        en_len++;
      end else if (en_prev && cur_valid) begin
        if (cur.len >= 0) checkOutput("cmd_en_len", 32'(en_len), 32'(cur.len));
        if (cur.by_ack) checkOutput("ack_at_en_fall", 32'(cpu_cmd_ack), 32'd1);
        cur_valid = 1'b0;
      end
      if (z80_data_oe && !oe_prev) begin
        checkOutput("status_expected", 32'(status_q.size() != 0), 32'd1);
        if (status_q.size() != 0) begin
          st = status_q.pop_front();
          checkOutput("status_value", 32'(z80_data_out), 32'(st));
        end
      end
      en_prev = cpu_cmd_en;
      oe_prev = z80_data_oe;
    end
  end

  initial begin : main
    z80_addr      = 16'h0000;
    z80_data_in   = 8'h00;
    z80_iorq_n    = 1'b1;
    z80_rd_n      = 1'b1;
    z80_wr_n      = 1'b1;
    z80_m1_n      = 1'b1;
    reset_reset_n = 1'b1;
    #2 reset_reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_reset_n = 1'b1;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("reset_cmd_en", 32'(cpu_cmd_en), 32'd0);
    checkOutput("reset_cmd", 32'(cpu_cmd), 32'h00);
    checkOutput("reset_oe", 32'(z80_data_oe), 32'd0);
    status_read(16'h00E5, 8'h00);

    $display("[TB] handshake");
    loader_mode = L_AUTO;
    ack_delay = 5;
    rel_delay = 3;
    expect_cmd(8'h42, 6, 1'b1);
    z80_out(16'h00E7, 8'h42);
    status_read(16'h00E5, 8'h80);
    repeat (10) @(negedge clk);
    status_read(16'h00E5, 8'h00);
    checkOutput("cmd_hold_42", 32'(cpu_cmd), 32'h42);
    checkOutput("cmd_en_idle", 32'(cpu_cmd_en), 32'd0);
    repeat (10) @(negedge clk);

    $display("[TB] overrun");
    ack_delay = 12;
    expect_cmd(8'h11, 13, 1'b1);
    z80_out(16'h00E7, 8'h11);
    z80_out(16'h00E7, 8'h22);
    status_read(16'h00E5, 8'hC0);
    status_read(16'h00E5, 8'h00);
    repeat (10) @(negedge clk);
    checkOutput("cmd_hold_11", 32'(cpu_cmd), 32'h11);

    $display("[TB] timeout");
    loader_mode = L_LOW;
    expect_cmd(8'h5A, 16, 1'b0);
    z80_out(16'h00E7, 8'h5A);
    repeat (20) @(negedge clk);
    status_read(16'h00E5, 8'h20);
    status_read(16'h00E5, 8'h00);

    $display("[TB] decode filtering");
    loader_mode = L_AUTO;
    ack_delay = 5;
    z80_out(16'h00E6, 8'h55);
    repeat (5) @(negedge clk);
    checkOutput("no_en_port_e6", 32'(cpu_cmd_en), 32'd0);
    applyStimulus(1'b1, 16'h00E7, 8'h66, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("no_en_m1_write", 32'(cpu_cmd_en), 32'd0);
    applyStimulus(1'b0, 16'h00E5, 8'h00, 1'b0);
    applyStimulus(1'b0, 16'h01FE, 8'h00, 1'b1);
    status_read(16'hABE5, 8'h00);
    checkOutput("cmd_unchanged_5a", 32'(cpu_cmd), 32'h5A);

    $display("[TB] fast ack");
    loader_mode = L_HIGH;
    repeat (3) @(negedge clk);
    expect_cmd(8'h99, 1, 1'b1);
    z80_out(16'h00E7, 8'h99);
    status_read(16'h00E5, 8'h80);
    loader_mode = L_LOW;
    repeat (5) @(negedge clk);
    status_read(16'h00E5, 8'h00);
    checkOutput("cmd_hold_99", 32'(cpu_cmd), 32'h99);

    $display("[TB] reset mid-operation");
    expect_cmd(8'h66, -1, 1'b0);
    z80_out(16'h00E7, 8'h66);
    z80_out(16'h00E7, 8'h67);
    @(negedge clk);
    #1 reset_reset_n = 1'b0;
    #1;
    checkOutput("async_reset_cmd_en", 32'(cpu_cmd_en), 32'd0);
    checkOutput("async_reset_cmd", 32'(cpu_cmd), 32'h00);
    repeat (2) @(negedge clk);
    #1 reset_reset_n = 1'b1;
    repeat (2) @(negedge clk);
    status_read(16'h00E5, 8'h00);
    loader_mode = L_AUTO;
    expect_cmd(8'h7F, 6, 1'b1);
    z80_out(16'h00E7, 8'h7F);
    repeat (15) @(negedge clk);
    status_read(16'h00E5, 8'h00);
    checkOutput("cmd_hold_7f", 32'(cpu_cmd), 32'h7F);

    for (int i = 0; i < 100 && (cmd_q.size() + status_q.size()) != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(cmd_q.size() + status_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/zx_cmd_port.md
Name: zx_cmd_port

Overview:
- Z80-side command initiator for the SD loader's CPU command handshake.
- The Spectrum writes a command byte to an I/O port. The block latches the byte, presents it as cpu_cmd, asserts cpu_cmd_en, and completes a four-phase handshake against cpu_cmd_ack from the Nios loader.
- A status port lets Z80 software poll busy, overrun and timeout.
- Sits in the top level between the Z80 bus pins and the loader's cpu_cmd/cpu_cmd_en/cpu_cmd_ack exports.

Parameters:
- CMD_PORT, 8'hE7, low address byte decoded for command writes.
- STATUS_PORT, 8'hE5, low address byte decoded for status reads.
- TIMEOUT, 24'd5000000, clk cycles to wait for an ack edge before aborting (100 ms at 50 MHz).

Ports:
- clk_clk  in  1  system clock, 50 MHz.
- reset_reset_n  in  1  asynchronous active-low reset.
- z80_addr  in  16  Z80 address bus; only bits 7:0 are decoded.
- z80_data_in  in  8  Z80 data bus as seen by the FPGA.
- z80_data_out  out  8  status byte driven to the Z80.
- z80_data_oe  out  1  data bus output enable, active high.
- z80_iorq_n  in  1  Z80 IORQ, asynchronous to clk_clk.
- z80_rd_n  in  1  Z80 RD, asynchronous.
- z80_wr_n  in  1  Z80 WR, asynchronous.
- z80_m1_n  in  1  Z80 M1, asynchronous; low qualifies interrupt acknowledge.
- cpu_cmd  out  8  latched command byte to the loader.
- cpu_cmd_en  out  1  command valid, level.
- cpu_cmd_ack  in  1  loader acknowledge, same clock domain.

Behaviour:
- Synchronisation
  - Signals iorq_n, rd_n, wr_n, m1_n each pass through a 2-FF synchroniser.
  - wr_strobe = synced (!iorq_n & !wr_n & m1_n).
  - rd_strobe = synced (!iorq_n & !rd_n & m1_n).
  - A third register detects edges.
- Command capture
  - On the rising edge of wr_strobe with z80_addr[7:0]==CMD_PORT, sample addr and data from a register captured on the previous clk. The bus has been stable more than 2 clks by then.
- Status read path is combinational from raw pins:
  - z80_data_oe = !z80_iorq_n & !z80_rd_n & z80_m1_n & (z80_addr[7:0]==STATUS_PORT).
  - z80_data_out = {busy, overrun, timeout, 5'b0}.
  - busy = (state != IDLE).
- Reset values
  - cpu_cmd = 8'h00, cpu_cmd_en = 0, state IDLE.
  - overrun = 0, timeout = 0, timer = 0.
  - z80_data_oe follows pins (combinational).
- FSM
  - IDLE: on a CMD_PORT write, cpu_cmd <= byte, cpu_cmd_en <= 1, timer <= 0, go to WAIT_ACK. cpu_cmd_en rises 1 clk after the detected strobe edge.
  - WAIT_ACK: if cpu_cmd_ack==1, cpu_cmd_en <= 0, timer <= 0, go to WAIT_REL. Else if timer==TIMEOUT-1, cpu_cmd_en <= 0, timeout <= 1, go to IDLE. Else timer++.
  - WAIT_REL: if cpu_cmd_ack==0, go to IDLE. Else if timer==TIMEOUT-1, timeout <= 1, go to IDLE. Else timer++.
- Boundary cases
  - cpu_cmd holds its value after the handshake until the next accepted write.
  - A CMD_PORT write while busy is ignored: cpu_cmd is unchanged and overrun <= 1 (sticky).
  - A CMD_PORT write in the same clk the FSM returns to IDLE is evaluated against the registered state, so it counts as busy → overrun.
  - overrun and timeout clear together on the falling edge of rd_strobe (end of read) with addr==STATUS_PORT. This keeps the data stable during the read cycle. If a set and a clear coincide, the set wins.
  - cpu_cmd_ack already high on entry to WAIT_ACK completes in 1 clk.
  - Timer width is 24 bits; it never wraps because it is bounded by TIMEOUT-1.
  - Cycles with M1 low (interrupt acknowledge) neither decode nor drive the bus.
  - Asynchronous reset mid-handshake forces IDLE and drops cpu_cmd_en immediately.

Test Plan:
- Handshake: OUT (0xE7),0x42; loader raises ack 5 clks after cpu_cmd_en, drops it 3 clks after en falls. Required: cpu_cmd=0x42, cpu_cmd_en high until 1 clk after ack; status read mid-handshake = 0x80, after completion = 0x00.
- Overrun: OUT 0x11 then OUT 0x22 before ack. Required: cpu_cmd stays 0x11; status read = 0xC0; a second read after the first completes = 0x80 or 0x00 (overrun cleared).
- Timeout: TIMEOUT=16, no ack. Required: cpu_cmd_en drops exactly 16 clks after rising; status = 0x20; the next read returns 0x00.
- Decode filtering:
  - OUT (0xE6),0x55 → no cpu_cmd_en.
  - IN from 0xE5 with m1_n=0 → z80_data_oe=0.
  - IN from 0x01FE → oe=0.
- Reset mid-operation: assert reset_reset_n=0 in WAIT_ACK. Required: cpu_cmd_en=0 and cpu_cmd=0x00 within the same cycle; after release, status=0x00 and a new OUT 0x7F completes normally.
- Fast ack: hold cpu_cmd_ack=1 before the write. Required: WAIT_ACK→WAIT_REL in 1 clk, cpu_cmd_en high for exactly 1 clk; IDLE only after ack drops.
